// File: rtl/regfile_wr_arbiter.sv
// Single write-port owner for the RV32 register file: post-reset clear sweep,
// then WB-priority arbitration with MDU/DBG round-robin and registered outputs.
module regfile_wr_arbiter #(
  parameter int                 NUM_REGS      = 32,
  parameter int                 ADDR_W        = 5,
  parameter int                 DATA_W        = 32,
  parameter bit                 INIT_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0]  INIT_VALUE    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              mdu_valid,
  input  logic [ADDR_W-1:0] mdu_addr,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              mdu_ready,
  input  logic              dbg_valid,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              dbg_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              init_done,
  output logic [1:0]        grant_id
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  typedef enum logic {RR_MDU, RR_DBG} rr_t;

  localparam logic [1:0]        GID_NONE = 2'd0;
  localparam logic [1:0]        GID_WB   = 2'd1;
  localparam logic [1:0]        GID_MDU  = 2'd2;
  localparam logic [1:0]        GID_DBG  = 2'd3;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
  localparam state_t            RST_STATE = INIT_ON_RESET ? ST_INIT : ST_RUN;

  state_t              state_q, state_d;
  rr_t                 rr_q, rr_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                sweep_last_q, sweep_last_d;
  logic                init_done_q, init_done_d;
  logic                rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]   rf_data_q, rf_data_d;
  logic [1:0]          grant_q, grant_d;

  logic                run;
  logic                wb_xfer, mdu_xfer, dbg_xfer;

  // Readies depend only on registered state and the current valids; a transfer
  // that coincides with rst is simply dropped by the reset branch below.
  always_comb begin
    run       = (state_q == ST_RUN);
    wb_ready  = run;
    mdu_ready = run & ~wb_valid & ((rr_q == RR_MDU) | ~dbg_valid);
    dbg_ready = run & ~wb_valid & ((rr_q == RR_DBG) | ~mdu_valid);
    wb_xfer   = wb_valid  & wb_ready;
    mdu_xfer  = mdu_valid & mdu_ready;
    dbg_xfer  = dbg_valid & dbg_ready;
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    idx_d        = idx_q;
    sweep_last_d = sweep_last_q;
    init_done_d  = init_done_q;
    rf_we_d      = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_data_d    = rf_data_q;
    grant_d      = GID_NONE;

    unique case (state_q)
      ST_INIT: begin
        // One idle cycle after the x(NUM_REGS-1) write before enabling arbitration.
        if (sweep_last_q) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end else begin
          rf_we_d      = 1'b1;
          rf_addr_d    = idx_q;
          rf_data_d    = INIT_VALUE;
          idx_d        = idx_q + FIRST_IDX;
          sweep_last_d = (idx_q == LAST_IDX);
        end
      end
      ST_RUN: begin
        if (wb_xfer) begin
          rf_we_d   = (wb_addr != '0);
          rf_addr_d = wb_addr;
          rf_data_d = wb_data;
          grant_d   = GID_WB;
        end else if (mdu_xfer) begin
          rf_we_d   = (mdu_addr != '0);
          rf_addr_d = mdu_addr;
          rf_data_d = mdu_data;
          grant_d   = GID_MDU;
          rr_d      = RR_DBG;
        end else if (dbg_xfer) begin
          rf_we_d   = (dbg_addr != '0);
          rf_addr_d = dbg_addr;
          rf_data_d = dbg_data;
          grant_d   = GID_DBG;
          rr_d      = RR_MDU;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RST_STATE;
      rr_q         <= RR_MDU;
      idx_q        <= FIRST_IDX;
      sweep_last_q <= 1'b0;
      init_done_q  <= ~INIT_ON_RESET;
      rf_we_q      <= 1'b0;
      rf_addr_q    <= '0;
      rf_data_q    <= '0;
      grant_q      <= GID_NONE;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      idx_q        <= idx_d;
      sweep_last_q <= sweep_last_d;
      init_done_q  <= init_done_d;
      rf_we_q      <= rf_we_d;
      rf_addr_q    <= rf_addr_d;
      rf_data_q    <= rf_data_d;
      grant_q      <= grant_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_addr   = rf_addr_q;
  assign rf_data   = rf_data_q;
  assign grant_id  = grant_q;
  assign init_done = init_done_q;

endmodule
